// File: rtl/vga_gpu_pkg.sv
// Shared definitions for the VGA GPU command path: opcodes, sequencer states, status byte.
package vga_gpu_pkg;

    localparam int unsigned CFG_W  = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 32;

    localparam logic [BYTE_W-1:0] OP_CFG  = 8'hA1;
    localparam logic [BYTE_W-1:0] OP_CHAR = 8'hA2;
    localparam logic [BYTE_W-1:0] OP_NOP  = 8'h00;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG_B3    = 3'd1,
        CFG_B2    = 3'd2,
        CFG_B1    = 3'd3,
        CFG_B0    = 3'd4,
        CHAR_ADDR = 3'd5,
        CHAR_DATA = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic       err;
        logic       cfg_pending;
        logic       busy;
        logic [4:0] rsvd;
    } status_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Counts idle cycles of an in-progress command; flags when the limit is reached.
module cmd_timeout_counter
    import vga_gpu_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expire_c = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/vga_config_sequencer.sv
// SPI command decoder: double-buffered display configuration with frame-synchronous
// commit, plus direct character-memory writes.
module vga_config_sequencer
    import vga_gpu_pkg::*;
#(
    parameter logic [31:0] RESET_CONFIG   = 32'h80FC_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        frame_start,
    output logic [31:0] config_out,
    output logic        cfg_pending,
    output logic        char_we,
    output logic [1:0]  char_x,
    output logic [2:0]  char_y,
    output logic        char_bit,
    output logic        busy,
    output logic        err,
    output logic [7:0]  tx_data
);

    seq_state_t       state_q, state_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] config_q, config_d;
    logic             pend_q, pend_d;
    logic             we_q, we_d;
    logic [1:0]       x_q, x_d;
    logic [2:0]       y_q, y_d;
    logic             bit_q, bit_d;
    logic             err_q, err_d;
    logic             busy_q;
    status_t          status_q, status_d;

    logic accept;
    logic expire_c;
    logic timeout;

    assign accept  = rx_valid & ena;
    // A byte arriving on the expiry cycle counts as activity and wins over the abort.
    assign timeout = ena & (state_q != IDLE) & expire_c & ~accept;

    cmd_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept | (state_d == IDLE)),
        .enable  (ena & (state_q != IDLE)),
        .expire_c(expire_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= RESET_CONFIG;
            config_q <= RESET_CONFIG;
            pend_q   <= 1'b0;
            we_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            bit_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            config_q <= config_d;
            pend_q   <= pend_d;
            we_q     <= we_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            busy_q   <= (state_d != IDLE);
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        config_d = config_q;
        pend_d   = pend_q;
        we_d     = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        bit_d    = bit_q;
        err_d    = err_q;

        // Commit uses the shadow as registered, so a coinciding last byte waits a frame.
        if (frame_start && pend_q) begin
            config_d = shadow_q;
            pend_d   = 1'b0;
        end

        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == OP_CFG) begin
                        state_d = CFG_B3;
                        err_d   = 1'b0;
                    end else if (rx_data == OP_CHAR) begin
                        state_d = CHAR_ADDR;
                        err_d   = 1'b0;
                    end else if (rx_data != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
                CFG_B3: begin
                    shadow_d[31:24] = rx_data;
                    state_d         = CFG_B2;
                end
                CFG_B2: begin
                    shadow_d[23:16] = rx_data;
                    state_d         = CFG_B1;
                end
                CFG_B1: begin
                    shadow_d[15:8] = rx_data;
                    state_d        = CFG_B0;
                end
                CFG_B0: begin
                    shadow_d[7:0] = rx_data;
                    pend_d        = 1'b1;
                    state_d       = IDLE;
                end
                CHAR_ADDR: begin
                    if (rx_data[7:5] != 3'b000) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        y_d     = rx_data[4:2];
                        x_d     = rx_data[1:0];
                        state_d = CHAR_DATA;
                    end
                end
                CHAR_DATA: begin
                    bit_d   = rx_data[0];
                    we_d    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        status_d             = '0;
        status_d.err         = err_d;
        status_d.cfg_pending = pend_d;
        status_d.busy        = (state_d != IDLE);
    end

    assign config_out  = config_q;
    assign cfg_pending = pend_q;
    assign char_we     = we_q;
    assign char_x      = x_q;
    assign char_y      = y_q;
    assign char_bit    = bit_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign tx_data     = status_q;

endmodule

// File: tb/tb_vga_config_sequencer.sv
// Self-checking bench: directed scenarios plus random byte streams against a command-level model.
module tb_vga_config_sequencer;

    localparam int unsigned TO      = 64;
    localparam logic [31:0] RST_CFG = 32'h80FC_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, rx_valid, frame_start;
    logic [7:0]  rx_data;
    logic [31:0] config_out;
    logic        cfg_pending, char_we, char_bit, busy, err;
    logic [1:0]  char_x;
    logic [2:0]  char_y;
    logic [7:0]  tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Command-level model state
    logic [31:0] m_cfg, m_shadow;
    logic        m_pend, m_err, m_we, m_bit;
    logic [1:0]  m_x;
    logic [2:0]  m_y;
    logic [7:0]  m_cmd[$];
    int unsigned m_idle;

    vga_config_sequencer #(
        .RESET_CONFIG  (RST_CFG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_start(frame_start),
        .config_out (config_out),
        .cfg_pending(cfg_pending),
        .char_we    (char_we),
        .char_x     (char_x),
        .char_y     (char_y),
        .char_bit   (char_bit),
        .busy       (busy),
        .err        (err),
        .tx_data    (tx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cfg    = RST_CFG;
        m_shadow = RST_CFG;
        m_pend   = 1'b0;
        m_err    = 1'b0;
        m_we     = 1'b0;
        m_bit    = 1'b0;
        m_x      = '0;
        m_y      = '0;
        m_cmd.delete();
        m_idle   = 0;
    endtask

    task automatic model_step(input logic e, input logic v, input logic [7:0] d, input logic f);
        int n;
        m_we = 1'b0;
        if (f && m_pend) begin
            m_cfg  = m_shadow;
            m_pend = 1'b0;
        end
        if (e && v) begin
            m_idle = 0;
            if (m_cmd.size() == 0) begin
                if (d == 8'hA1 || d == 8'hA2) begin
                    m_cmd.push_back(d);
                    m_err = 1'b0;
                end else if (d != 8'h00) begin
                    m_err = 1'b1;
                end
            end else begin
                m_cmd.push_back(d);
                n = m_cmd.size();
                if (m_cmd[0] == 8'hA1) begin
                    m_shadow[8*(5-n) +: 8] = d;
                    if (n == 5) begin
                        m_pend = 1'b1;
                        m_cmd.delete();
                    end
                end else if (n == 2) begin
                    if (d[7:5] != 3'b000) begin
                        m_err = 1'b1;
                        m_cmd.delete();
                    end else begin
                        m_y = d[4:2];
                        m_x = d[1:0];
                    end
                end else begin
                    m_bit = d[0];
                    m_we  = 1'b1;
                    m_cmd.delete();
                end
            end
        end else if (e && m_cmd.size() != 0) begin
            if (m_idle == TO - 1) begin
                m_cmd.delete();
                m_err  = 1'b1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic compare_all();
        logic b;
        b = (m_cmd.size() != 0);
        check("config_out", config_out, m_cfg);
        check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        check("busy", 32'(busy), 32'(b));
        check("err", 32'(err), 32'(m_err));
        check("char_we", 32'(char_we), 32'(m_we));
        check("char_x", 32'(char_x), 32'(m_x));
        check("char_y", 32'(char_y), 32'(m_y));
        check("char_bit", 32'(char_bit), 32'(m_bit));
        check("tx_data", 32'(tx_data), 32'({m_err, m_pend, b, 5'b0}));
    endtask

    task automatic step(input logic e, input logic v, input logic [7:0] d, input logic f);
        @(negedge clk);
        ena         = e;
        rx_valid    = v;
        rx_data     = d;
        frame_start = f;
        model_step(e, v, d, f);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        ena         = 1'b0;
        rx_valid    = 1'b0;
        frame_start = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] sv_cfg;
        logic        sv_pend;
        logic [7:0]  d;
        logic        e, v, f;
        int          r, quiet;

        rst_n = 1'b0; ena = 1'b0; rx_valid = 1'b0; rx_data = '0; frame_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_cfg", config_out, 32'h80FC_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic config load and frame commit
        send(8'hA1); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        check("cfg_pend_after_b0", 32'(cfg_pending), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("cfg_commit", config_out, 32'h1234_5678);
        check("cfg_pend_clear", 32'(cfg_pending), 32'd0);

        // Last byte coinciding with frame_start defers the commit
        apply_reset();
        send(8'hA1); send(8'hDE); send(8'hAD); send(8'hBE);
        step(1'b1, 1'b1, 8'hEF, 1'b1);
        check("coincide_hold", config_out, 32'h80FC_0000);
        idle(2);
        check("coincide_still", config_out, 32'h80FC_0000);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("coincide_next", config_out, 32'hDEAD_BEEF);

        // Character write
        send(8'hA2); send(8'h1D); send(8'h01);
        check("char_we_pulse", 32'(char_we), 32'd1);
        check("char_y_val", 32'(char_y), 32'd7);
        check("char_x_val", 32'(char_x), 32'd1);
        idle(1);
        check("char_we_single", 32'(char_we), 32'd0);
        check("char_busy_done", 32'(busy), 32'd0);

        // Protocol errors and clearing
        send(8'h55);
        check("bad_op_err", 32'(err), 32'd1);
        send(8'hA2); send(8'h20);
        check("bad_addr_err", 32'(err), 32'd1);
        idle(2);
        send(8'hA1);
        check("err_cleared", 32'(err), 32'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);

        // Timeout boundary
        sv_cfg  = config_out;
        sv_pend = cfg_pending;
        send(8'hA1); send(8'h11);
        idle(TO - 1);
        check("to_not_yet", 32'(busy), 32'd1);
        idle(1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_cfg", config_out, sv_cfg);
        check("to_pend", 32'(cfg_pending), 32'(sv_pend));

        // Reset mid-command abandons it
        send(8'hA1); send(8'hAA); send(8'hBB);
        apply_reset();
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("rst_cfg_kept", config_out, 32'h80FC_0000);
        send(8'hA2); send(8'h05);
        apply_reset();
        idle(2);

        // Random byte streams with occasional quiet stretches and resets
        for (int blk = 0; blk < 16; blk++) begin
            quiet = (blk % 3 == 2);
            for (int c = 0; c < 200; c++) begin
                e = ($urandom_range(0, 9) != 0);
                v = quiet ? ($urandom_range(0, 99) < 1) : ($urandom_range(0, 9) < 4);
                f = ($urandom_range(0, 19) == 0);
                r = $urandom_range(0, 9);
                if (r < 3)       d = 8'hA1;
                else if (r < 5)  d = 8'hA2;
                else if (r == 5) d = 8'h00;
                else if (r == 6) d = 8'($urandom_range(0, 31));
                else             d = 8'($urandom);
                step(e, v, d, f);
            end
            if (blk % 5 == 4) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_config_sequencer.md
VGA_CONFIG_SEQUENCER -- requirements
Module: vga_config_sequencer

Interface
REQ-001 SHALL have parameter RESET_CONFIG, default 32'h80FC_0000; the value config_out takes at reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024; the idle-byte limit before an incomplete command is aborted.
REQ-003 SHALL have ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  design enable.
- rx_valid  in  1  one-cycle strobe; SPI byte available.
- rx_data  in  8  received SPI byte.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- config_out  out  32  live configuration to pixel mux.
- cfg_pending  out  1  shadow config waiting for frame_start.
- char_we  out  1  one-cycle char memory write strobe.
- char_x  out  2  char memory column.
- char_y  out  3  char memory row.
- char_bit  out  1  char memory write data.
- busy  out  1  command in progress (state != IDLE).
- err  out  1  sticky protocol error.
- tx_data  out  8  status byte for SPI MISO: {err, cfg_pending, busy, 5'b0}.

Function
REQ-004 SHALL implement FSM states IDLE, CFG_B3, CFG_B2, CFG_B1, CFG_B0, CHAR_ADDR, CHAR_DATA; a byte is accepted only when rx_valid=1 and ena=1.
REQ-005 In IDLE: byte 0xA1 -> CFG_B3; 0xA2 -> CHAR_ADDR; 0x00 -> stay IDLE, no effect (NOP, used to clock out tx_data); any other byte -> stay IDLE, set err.
REQ-006 CFG_B3..CFG_B0 SHALL capture bytes MSB-first into shadow[31:24]..shadow[7:0]; accepting the CFG_B0 byte -> IDLE and sets cfg_pending on the same edge.
REQ-007 On the edge where frame_start=1 and cfg_pending=1 (as registered), config_out <= shadow and cfg_pending <= 0.
REQ-008 If the last config byte and frame_start coincide, config_out SHALL NOT update; the commit occurs at the next frame_start.
REQ-009 A new 0xA1 sequence while cfg_pending=1 SHALL overwrite the shadow byte by byte; cfg_pending stays 1; the commit uses whatever the shadow holds at frame_start.
REQ-010 CHAR_ADDR byte: bits [7:5] must be 0, else err set and -> IDLE. Otherwise char_y <= byte[4:2], char_x <= byte[1:0], -> CHAR_DATA.
REQ-011 CHAR_DATA byte: char_bit <= byte[0]; char_we =1 for exactly the one cycle after acceptance; -> IDLE. Char writes are not frame-synchronised.
REQ-012 A 32-bit timeout counter SHALL clear on every accepted byte and on entering IDLE, and increment each ena=1 cycle while not IDLE. On reaching TIMEOUT_CYCLES-1 -> IDLE, set err, discard the partial command; cfg_pending is unaffected.
REQ-013 While ena=0: FSM, shadow and timeout counter hold; frame_start commit still operates.
REQ-014 err SHALL clear on the edge that accepts a valid command byte (0xA1/0xA2) in IDLE; an error and a clear in the same cycle are impossible by REQ-005.
REQ-015 busy, tx_data and config_out SHALL be registered or derived directly from registers; no combinational path from rx_data to outputs.

Reset
REQ-016 While rst_n=0: state=IDLE, config_out=RESET_CONFIG, shadow=RESET_CONFIG, cfg_pending=0, char_we=0, char_x=0, char_y=0, char_bit=0, err=0, timeout=0, tx_data=0.
REQ-017 Reset asserted mid-command SHALL abandon it; no char_we pulse or config commit follows deassertion.

Structure
REQ-018 Command opcodes (0xA1, 0xA2, 0x00) and the FSM state encoding SHALL live in a shared package, vga_gpu_pkg.
REQ-019 The timeout counter SHALL be a sub-module, cmd_timeout_counter (clear, enable, expire outputs).

Verification
REQ-020 Bytes A1,12,34,56,78, then a frame_start pulse -> cfg_pending=1 after byte 5; config_out=32'h12345678 and cfg_pending=0 the cycle after frame_start.
REQ-021 A1,DE,AD,BE,EF with frame_start on the cycle of EF -> config_out stays 80FC0000; updates to DEADBEEF at the next frame_start.
REQ-022 A2,0x1D,0x01 -> single char_we pulse with char_y=3'b111, char_x=2'b01, char_bit=1; busy=0 afterwards.
REQ-023 Opcode 0x55 -> err=1, state IDLE; A2,0x20 -> err=1, no char_we; a following A1 clears err.
REQ-024 A1,11 then silence for TIMEOUT_CYCLES cycles -> busy=0, err=1, config_out and cfg_pending unchanged.
REQ-025 rst_n pulsed low after A1,AA,BB -> all outputs at reset values; a following frame_start leaves config_out=80FC0000.
